// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the bit-serial ALU.
package alu_pkg;

   localparam logic [2:0] ALU_PASS_B = 3'b000;
   localparam logic [2:0] ALU_ADD    = 3'b010;
   localparam logic [2:0] ALU_SUB    = 3'b011;
   localparam logic [2:0] ALU_AND    = 3'b100;
   localparam logic [2:0] ALU_OR     = 3'b101;
   localparam logic [2:0] ALU_XOR    = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_1_bit.sv
// One-bit ALU slice. Subtraction inverts B; the caller seeds carry-in with 1.
module alu_1_bit
   import alu_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic       c_i,
   input  logic [2:0] ctrl_i,
   output logic       y_o,
   output logic       c_o
);

   logic b_eff;

   always_comb begin
      b_eff = (ctrl_i == ALU_SUB) ? ~b_i : b_i;
      y_o   = 1'b0;
      c_o   = 1'b0;
      case (ctrl_i)
         ALU_PASS_B: y_o = b_i;
         ALU_ADD, ALU_SUB: begin
            y_o = a_i ^ b_eff ^ c_i;
            c_o = (a_i & b_eff) | (a_i & c_i) | (b_eff & c_i);
         end
         ALU_AND: y_o = a_i & b_i;
         ALU_OR:  y_o = a_i | b_i;
         ALU_XOR: y_o = a_i ^ b_i;
         default: y_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: one bit per RUN cycle, LSB first, one-cycle DONE pulse.
// Flag outputs are built only when ALU_SERIAL_FLAGS_EN is defined; otherwise tied to 0.
module alu_serial_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       ctrl,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out,
   output logic [1:0]       dbg_state_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] sr_q, sr_d, result_q, result_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             slice_y, slice_c;
   logic             last_bit;

   // Operands shift right so the slice always sees bit 0 of the registers.
   alu_1_bit u_slice (
      .a_i    (a_q[0]),
      .b_i    (b_q[0]),
      .c_i    (carry_q),
      .ctrl_i (ctrl_q),
      .y_o    (slice_y),
      .c_o    (slice_c)
   );

   assign last_bit = (state_q == ST_RUN) && (cnt_q == LAST);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      ctrl_d   = ctrl_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      sr_d     = sr_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = a;
               b_d     = b;
               ctrl_d  = ctrl;
               cnt_d   = '0;
               carry_d = ctrl[0];
            end
         end
         ST_RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = slice_c;
            sr_d    = {slice_y, sr_q[WIDTH-1:1]};
            if (cnt_q == LAST) begin
               state_d  = ST_DONE;
               result_d = sr_d;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         sr_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ctrl_q   <= ctrl_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         sr_q     <= sr_d;
         result_q <= result_d;
      end
   end

`ifdef ALU_SERIAL_FLAGS_EN
   logic neg_q, zero_q, ovf_q, cout_q;
   logic arith;

   assign arith = (ctrl_q == ALU_ADD) || (ctrl_q == ALU_SUB);

   // carry_q holds the carry into the MSB during the last RUN cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         neg_q  <= 1'b0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
         cout_q <= 1'b0;
      end else if (last_bit) begin
         neg_q  <= slice_y;
         zero_q <= (sr_d == '0);
         ovf_q  <= arith & (carry_q ^ slice_c);
         cout_q <= arith & slice_c;
      end
   end

   assign negative  = neg_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;
   assign carry_out = cout_q;
`else
   logic unused_last;
   assign unused_last = last_bit;
   assign negative    = 1'b0;
   assign zero        = 1'b0;
   assign overflow    = 1'b0;
   assign carry_out   = 1'b0;
`endif

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign result      = result_q;
   assign dbg_state_o = state_q;

endmodule
